// File: rtl/control_sequencer.sv
// control_sequencer: two-cycle instruction fetch, decode, and a one-hot timed execute
// sequence that drives every control input of the ALU system datapath.
module control_sequencer #(
  parameter logic [5:0]  HLT_OP = 6'h3F,
  parameter int unsigned T_W    = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [15:0]    IROut,
  input  logic [3:0]     FlagsOut,
  output logic [2:0]     RF_OutASel,
  output logic [2:0]     RF_OutBSel,
  output logic [2:0]     RF_FunSel,
  output logic [3:0]     RF_RegSel,
  output logic [3:0]     RF_ScrSel,
  output logic [4:0]     ALU_FunSel,
  output logic           ALU_WF,
  output logic [1:0]     ARF_OutCSel,
  output logic [1:0]     ARF_OutDSel,
  output logic [1:0]     ARF_FunSel,
  output logic [2:0]     ARF_RegSel,
  output logic           IR_LH,
  output logic           IR_Write,
  output logic           Mem_WR,
  output logic           Mem_CS,
  output logic [1:0]     MuxASel,
  output logic [1:0]     MuxBSel,
  output logic [1:0]     MuxCSel,
  output logic           MuxDSel,
  output logic [1:0]     DR_FunSel,
  output logic           DR_E,
  output logic [T_W-1:0] T,
  output logic           Halted
);

  typedef enum logic [2:0] {
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [5:0] op;
  logic [1:0] rd;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [3:0] rd_en;
  logic       z_flag;

  assign op     = IROut[15:10];
  assign rd     = IROut[9:8];
  assign s1     = IROut[5:3];
  assign s2     = IROut[2:0];
  assign z_flag = FlagsOut[3];

  // The immediate byte goes straight to the datapath; only Z steers control.
  logic unused_inputs;
  assign unused_inputs = ^{IROut[7:6], FlagsOut[2:0]};

  // Active-low one-hot register enable: R1=0111 .. R4=1110
  always_comb begin
    rd_en = '1;
    rd_en[3 - rd] = 1'b0;
  end

  // Timing state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_T0;
    else        state <= state_nxt;
  end

  // Next timing state: fetch low, fetch high, execute, optional LD writeback
  always_comb begin
    state_nxt = S_T0;
    case (state)
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2: begin
        if (op == HLT_OP)     state_nxt = S_HALT;
        else if (op == 6'h03) state_nxt = S_T3;
        else                  state_nxt = S_T0;
      end
      S_T3:   state_nxt = S_T0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_T0;
    endcase
  end

  // Control outputs: idle set by default; overridden per timing state and opcode
  always_comb begin
    RF_OutASel  = '0;
    RF_OutBSel  = '0;
    RF_FunSel   = '0;
    RF_RegSel   = '1;
    RF_ScrSel   = '1;
    ALU_FunSel  = '0;
    ALU_WF      = 1'b0;
    ARF_OutCSel = '0;
    ARF_OutDSel = '0;
    ARF_FunSel  = '0;
    ARF_RegSel  = '1;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = '0;
    MuxBSel     = '0;
    MuxCSel     = '0;
    MuxDSel     = 1'b0;
    DR_FunSel   = '0;
    DR_E        = 1'b0;

    // Reset gates every control output so an abandoned instruction cannot write.
    if (Reset) begin
      case (state)
        S_T0, S_T1: begin
          ARF_OutDSel = 2'b00;
          Mem_CS      = 1'b0;
          Mem_WR      = 1'b0;
          IR_Write    = 1'b1;
          IR_LH       = (state == S_T1);
          ARF_FunSel  = 2'b01;
          ARF_RegSel  = 3'b011;
        end
        S_T2: begin
          if (op != HLT_OP) begin
            case (op)
              6'h01: begin
                MuxASel   = 2'b11;
                RF_FunSel = 3'b010;
                RF_RegSel = rd_en;
              end
              6'h02: begin
                MuxBSel    = 2'b11;
                ARF_FunSel = 2'b10;
                ARF_RegSel = 3'b101;
              end
              6'h03: begin
                ARF_OutDSel = 2'b10;
                Mem_CS      = 1'b0;
                DR_E        = 1'b1;
                DR_FunSel   = 2'b01;
              end
              6'h04: begin
                RF_OutASel  = {1'b0, rd};
                MuxDSel     = 1'b0;
                ALU_FunSel  = 5'b10000;
                MuxCSel     = 2'b00;
                ARF_OutDSel = 2'b10;
                Mem_CS      = 1'b0;
                Mem_WR      = 1'b1;
              end
              6'h05: begin
                MuxBSel    = 2'b11;
                ARF_FunSel = 2'b10;
                ARF_RegSel = 3'b011;
              end
              6'h06: begin
                if (!z_flag) begin
                  MuxBSel    = 2'b11;
                  ARF_FunSel = 2'b10;
                  ARF_RegSel = 3'b011;
                end
              end
              default: begin
                if (op[5:4] == 2'b01) begin
                  RF_OutASel = s1;
                  RF_OutBSel = s2;
                  MuxDSel    = 1'b0;
                  ALU_FunSel = {1'b1, op[3:0]};
                  ALU_WF     = 1'b1;
                  MuxASel    = 2'b00;
                  RF_FunSel  = 3'b010;
                  RF_RegSel  = rd_en;
                end
              end
            endcase
          end
        end
        S_T3: begin
          MuxASel   = 2'b10;
          RF_FunSel = 3'b010;
          RF_RegSel = rd_en;
        end
        default: ;
      endcase
    end
  end

  // Visible timing state and halt indication
  always_comb begin
    T      = '0;
    Halted = 1'b0;
    case (state)
      S_T0:   T[0]   = 1'b1;
      S_T1:   T[1]   = 1'b1;
      S_T2:   T[2]   = 1'b1;
      S_T3:   T[3]   = 1'b1;
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Control unit that drives every control input of the ALU system datapath.
- Fetches 16-bit instructions from byte memory in two cycles: low byte, then high byte.
- Decodes the instruction and sequences execute cycles with a one-hot timing counter.
- Sits beside the datapath; its only feedback inputs are the IR contents and the ALU flags.

Parameters:
HLT_OP, 6'h3F, opcode that enters HALT
T_W, 4, width of timing state (one-hot T0..T3)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
IROut  input  16  instruction register contents
FlagsOut  input  4  ALU flags {Z,C,N,O}; Z=FlagsOut[3]
RF_OutASel, RF_OutBSel  output  3 each  register file read selects (R1..R4 = 3'b000..3'b011)
RF_FunSel  output  3  3'b010 = load
RF_RegSel, RF_ScrSel  output  4 each  active-low enables; R1=0111, R2=1011, R3=1101, R4=1110
ALU_FunSel  output  5  ALU operation
ALU_WF  output  1  flag write enable
ARF_OutCSel, ARF_OutDSel  output  2 each  PC=00, SP=01, AR=10
ARF_FunSel  output  2  01 = increment, 10 = load
ARF_RegSel  output  3  active-low {PC,AR,SP}; PC=011, AR=101, SP=110
IR_LH  output  1  0 = low byte, 1 = high byte
IR_Write  output  1  IR load enable
Mem_WR  output  1  1 = write
Mem_CS  output  1  active-low chip select
MuxASel, MuxBSel, MuxCSel  output  2 each  datapath muxes
MuxDSel  output  1  ALU A source
DR_FunSel  output  2  01 = load low byte, zero-extend
DR_E  output  1  data register enable
T  output  4  current timing state, one-hot
Halted  output  1  high in HALT

Behaviour:
- Idle output set (all outputs default to this unless a step below overrides):
  - RF_RegSel = RF_ScrSel = 1111; ARF_RegSel = 111; Mem_CS = 1.
  - IR_Write, Mem_WR, ALU_WF, DR_E = 0; every select and FunSel = 0.
- Reset low:
  - T = 0001 (T0), Halted = 0.
  - All outputs forced to the idle set, independent of state.
  - Reset mid-instruction abandons the instruction; no partial writes after release.
- Outputs are combinational from {T, IROut, FlagsOut}. State advances on each rising edge of Clock.
- T0 (fetch low byte):
  - ARF_OutDSel = 00; Mem_CS = 0; Mem_WR = 0; IR_Write = 1; IR_LH = 0.
  - ARF_FunSel = 01, ARF_RegSel = 011 (PC++).
  - Next: T1.
- T1 (fetch high byte): same outputs as T0 but IR_LH = 1. Next: T2.
- Decode fields: op = IROut[15:10]; rd = IROut[9:8]; s1 = IROut[5:3]; s2 = IROut[2:0]; imm = IROut[7:0].
- T2 (execute), by opcode:
  - 0x01 LDIM: MuxASel = 11, RF_FunSel = 010, RF_RegSel = enable(rd). Next: T0.
  - 0x02 LDAR: MuxBSel = 11, ARF_FunSel = 10, ARF_RegSel = 101. Next: T0.
  - 0x03 LD: ARF_OutDSel = 10, Mem_CS = 0, DR_E = 1, DR_FunSel = 01. Next: T3.
  - 0x04 ST: RF_OutASel = {1'b0, rd}, MuxDSel = 0, ALU_FunSel = 5'b10000 (pass A), MuxCSel = 00, ARF_OutDSel = 10, Mem_CS = 0, Mem_WR = 1. Next: T0.
  - 0x05 BRA: MuxBSel = 11, ARF_FunSel = 10, ARF_RegSel = 011. Next: T0.
  - 0x06 BNE: same as BRA only when FlagsOut[3] = 0; otherwise idle. Next: T0.
  - 0x10–0x1F ALU: RF_OutASel = s1, RF_OutBSel = s2, MuxDSel = 0, ALU_FunSel = {1'b1, op[3:0]}, ALU_WF = 1, MuxASel = 00, RF_FunSel = 010, RF_RegSel = enable(rd). Next: T0.
  - HLT_OP: idle outputs; Halted = 1 from the next edge. Next: HALT.
  - Any other opcode: NOP (idle outputs). Next: T0.
- T3 (LD writeback only): MuxASel = 10, RF_FunSel = 010, RF_RegSel = enable(rd). Next: T0.
- HALT: T = 0000, idle outputs, Halted = 1. Only Reset exits.
- PC wraps 0xFFFF -> 0x0000 inside the ARF; no special handling here.
- Instruction timing: every instruction takes 3 cycles (fetch + execute), except LD, which takes 4.

Test Plan:
- Reset low mid-T1 -> outputs idle immediately (Mem_CS = 1, IR_Write = 0); after release, first edge is T0 with ARF_OutDSel = 00.
- mem[0..1] = 5A,05 (LDIM R2,0x5A) -> T0/T1 IR_LH = 0/1; T2 has RF_RegSel = 1011, MuxASel = 11; next T = 0001; PC = 2; R2 = 0x0000005A.
- mem = 10,08 then 00,0C (LDAR 0x10; LD R1), mem[0x10] = 7F -> LD spends 4 cycles; T3 has RF_RegSel = 0111, MuxASel = 10; R1 = 0x7F.
- Instruction 0x5013 (ALU op 0x14, rd = R1, s1 = R3, s2 = R4) -> T2 has ALU_FunSel = 10100, RF_OutASel = 010, RF_OutBSel = 011, ALU_WF = 1, RF_RegSel = 0111.
- BNE 0x1820 with FlagsOut = 1000 -> no PC load; with FlagsOut = 0000 -> ARF_FunSel = 10, ARF_RegSel = 011, next fetch from 0x20.
- Opcode 0x3F -> Halted = 1, T = 0000, Mem_CS held 1 for 20 cycles; Reset low then high -> restart at T0.
